mdp3_serializer: RTL

MDP3_SERIALIZER -- requirements
Module: mdp3_serializer

---
 rtl/mdp3_serializer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mdp3_serializer.sv
//------------------------------------------------------------------------------
// Module      : mdp3_serializer
// Description : Captures one MDP3 book-update field set and emits it as five
//               64-bit wire beats (beat 0..4) under valid/ready flow control.
//               Price and quantity are byte-reversed onto the wire. Supports
//               back-to-back messages with no idle beat between them.
// Options     : `define MDP3_SER_SEQ_EN to place a 16-bit wrapping sequence
//               counter in beat 0; otherwise beat 0 is all zeros.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdp3_serializer #(
    parameter logic [15:0] SEQ_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  ACTION,
    input  logic [1:0]  ENTRY_TYPE,
    input  logic [63:0] PRICE,
    input  logic [15:0] QUANTITY,
    input  logic [7:0]  NUM_ORDERS,
    output logic [63:0] MESSAGE,
    output logic        beat_valid,
    input  logic        beat_ready,
    output logic        done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [2:0] c_last_beat = 3'd4;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [2:0]  r_beat;
    logic [2:0]  w_beat_nxt;
    logic        w_load;
    logic        w_last_acc;
    logic        w_hs;

    logic [1:0]  r_action;
    logic [1:0]  r_entry_type;
    logic [63:0] r_price;
    logic [15:0] r_quantity;
    logic [7:0]  r_num_orders;

    logic [63:0] w_price_rev;
    logic [15:0] w_qty_rev;
    logic [63:0] w_beat0;

    // Ready in IDLE, or on the final beat when it is being accepted, so a new
    // message can follow without a gap. Held low throughout reset.
    assign in_ready   = !reset && ((r_state == S_IDLE) ||
                                   ((r_beat == c_last_beat) && beat_ready));
    assign w_hs       = in_valid && in_ready;
    assign beat_valid = (r_state == S_SEND);
    assign done       = (r_state == S_SEND) && (r_beat == c_last_beat);

    // Byte 0 of the host value becomes byte 7 on the wire.
    assign w_price_rev = {r_price[7:0],   r_price[15:8],  r_price[23:16], r_price[31:24],
                          r_price[39:32], r_price[47:40], r_price[55:48], r_price[63:56]};
    assign w_qty_rev   = {r_quantity[7:0], r_quantity[15:8]};

`ifdef MDP3_SER_SEQ_EN
    logic [15:0] r_seq;

    // Sequence number advances once per fully delivered message.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq <= SEQ_INIT;
        end else if (w_last_acc) begin
            r_seq <= r_seq + 16'd1;
        end
    end

    assign w_beat0 = {48'd0, r_seq};
`else
    logic w_unused_seq_init;
    assign w_unused_seq_init = ^SEQ_INIT;
    assign w_beat0           = 64'd0;
`endif

    // State and beat index register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_beat  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // Field capture on handshake; the message in flight is isolated from inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_action     <= 2'd0;
            r_entry_type <= 2'd0;
            r_price      <= 64'd0;
            r_quantity   <= 16'd0;
            r_num_orders <= 8'd0;
        end else if (w_load) begin
            r_action     <= ACTION;
            r_entry_type <= ENTRY_TYPE;
            r_price      <= PRICE;
            r_quantity   <= QUANTITY;
            r_num_orders <= NUM_ORDERS;
        end
    end

    // Next-state: beat index moves only when the current beat is accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_load      = 1'b0;
        w_last_acc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = S_SEND;
                    w_beat_nxt  = 3'd0;
                    w_load      = 1'b1;
                end
            end
            S_SEND: begin
                if (beat_ready) begin
                    if (r_beat == c_last_beat) begin
                        w_last_acc = 1'b1;
                        w_beat_nxt = 3'd0;
                        if (w_hs) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_beat_nxt = r_beat + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_beat_nxt  = 3'd0;
            end
        endcase
    end

    // Beat formatter; all zeros whenever no beat is being presented.
    always_comb begin
        MESSAGE = 64'd0;
        if (r_state == S_SEND) begin
            case (r_beat)
                3'd0:    MESSAGE = w_beat0;
                3'd1:    MESSAGE = {38'd0, r_action, 6'd0, r_entry_type, 16'd0};
                3'd2:    MESSAGE = {48'd0, w_price_rev[63:48]};
                3'd3:    MESSAGE = {w_price_rev[47:0], w_qty_rev};
                3'd4:    MESSAGE = {r_num_orders, 56'd0};
                default: MESSAGE = 64'd0;
            endcase
        end
    end

endmodule

`default_nettype wire
